order_serializer: RTL and testbench
===================================

Name: order_serializer

Overview:
- Outbound end of the decision interface: takes the single-cycle decision strobe and fields from the trading decision stage and emits one byte-serial order frame per decision.
- Output is a valid/ready byte stream that feeds the TX MAC/UART path.
- The decision interface has no backpressure, so decisions are buffered in a small FIFO.
- Decisions arriving while the FIFO is full are dropped and counted.

Parameters:
- FIFO_DEPTH, 4, number of buffered decisions; must be a power of 2, ≥2.
- ORDER_TYPE, 8'h42, byte 0 of every frame (ASCII 'B').

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- decision_valid  in  1  single-cycle decision strobe
- decision_type  in  8  source message type, echoed in frame
- d_order_id  in  64  order id
- d_price  in  32  price
- d_volume  in  32  volume
- tx_data  out  8  frame byte
- tx_valid  out  1  tx_data valid
- tx_last  out  1  high with the final (checksum) byte
- tx_ready  in  1  downstream accepts byte when tx_valid && tx_ready
- busy  out  1  high in SEND state
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently in the FIFO
- overflow  out  1  one-cycle pulse when a decision is dropped
- drop_count  out  16  dropped decisions, saturating

Behaviour:
- Reset (async assert, sync release):
  - tx_valid, tx_last, busy, and overflow go to 0.
  - tx_data, fifo_level, and drop_count go to 0.
  - FIFO is emptied and the state machine goes to IDLE.
  - Reset mid-frame abandons the frame; no resumption after release.
- Frame format, 19 bytes, MSB-first per field:
  - b0 = ORDER_TYPE
  - b1 = decision_type
  - b2..b9 = d_order_id[63:0]
  - b10..b13 = d_price
  - b14..b17 = d_volume
  - b18 = XOR of b0..b17
- FIFO push: on decision_valid when level < FIFO_DEPTH, using the level at the start of the cycle.
  - If level == FIFO_DEPTH, the decision is dropped even if a pop occurs in the same cycle.
  - On a drop: overflow pulses for 1 cycle; drop_count increments and saturates at 16'hFFFF.
  - Push and pop in the same cycle leave the level unchanged.
- State machine IDLE:
  - If FIFO is non-empty: pop the head into a 152-bit frame register (checksum computed at load), set byte index = 0, go to SEND.
  - If FIFO is empty: remain in IDLE.
  - tx_valid = 0 in IDLE.
- State machine SEND:
  - tx_valid = 1; tx_data = frame byte[index]; tx_last = (index == 18).
  - On handshake with index < 18: index increments and the next byte appears the following cycle.
  - On handshake with index == 18: go to IDLE.
  - While tx_valid && !tx_ready: tx_data and tx_last are held stable.
  - tx_valid never deasserts before a handshake.
- Latency: decision_valid in cycle N with the FIFO empty and in IDLE gives pop in N+1 and b0 with tx_valid in N+2.
- Inter-frame gap: exactly one cycle with tx_valid = 0 (the IDLE pop cycle) between the b18 handshake and the next b0.
- Throughput with tx_ready held high: 20 cycles per frame.
- busy = (state == SEND), registered.
- Inputs are sampled only when decision_valid = 1; field values are otherwise ignored.

Test Plan:
- Single frame:
  - Stimulus: decision_type=0x54, order_id=0x0102030405060708, price=0x00002710, volume=0x00000064, tx_ready=1, ORDER_TYPE default.
  - Required bytes: 42 54 01 02 03 04 05 06 07 08 00 00 27 10 00 00 00 64 4D.
  - tx_last only on 0x4D; first tx_valid exactly 2 cycles after decision_valid.
- Backpressure: same decision with tx_ready toggling 1,0,0,1 pseudo-randomly.
  - Identical byte sequence; tx_data stable while stalled; no byte duplicated or skipped.
- Overflow: 6 decisions on consecutive cycles with tx_ready=0.
  - 5 accepted (1 in frame register + 4 in FIFO), 1 dropped.
  - overflow pulses once; drop_count=1; fifo_level=4.
  - After tx_ready=1, exactly 5 frames emitted in order.
- Back-to-back: 2 decisions with tx_ready=1.
  - Frame 2's b0 appears exactly 2 cycles after frame 1's b18 handshake (one gap cycle).
- Reset mid-frame: assert rst_n=0 during byte 7.
  - All outputs 0 immediately (async); fifo_level=0.
  - After release, no further bytes until a new decision arrives.
- drop_count saturation: force 65,540 drops with tx_ready=0.
  - drop_count holds 0xFFFF; overflow still pulses for each drop.

Source files
------------

// File: rtl/order_serializer_if.sv
// Bundles the decision strobe/fields, the outbound byte stream and the status
// outputs of the order serializer. The DUT uses the slave modport.
`timescale 1ns/1ps

interface order_serializer_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                          decision_valid;
    logic [7:0]                    decision_type;
    logic [63:0]                   d_order_id;
    logic [31:0]                   d_price;
    logic [31:0]                   d_volume;

    logic [7:0]                    tx_data;
    logic                          tx_valid;
    logic                          tx_last;
    logic                          tx_ready;

    logic                          busy;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic                          overflow;
    logic [15:0]                   drop_count;

    modport slave (
        input  decision_valid, decision_type, d_order_id, d_price, d_volume,
        input  tx_ready,
        output tx_data, tx_valid, tx_last,
        output busy, fifo_level, overflow, drop_count
    );

    modport master (
        output decision_valid, decision_type, d_order_id, d_price, d_volume,
        output tx_ready,
        input  tx_data, tx_valid, tx_last,
        input  busy, fifo_level, overflow, drop_count
    );
endinterface

// File: rtl/order_serializer.sv
// Buffers single-cycle trading decisions in a small FIFO and emits each one as
// a 19-byte frame (type, message type, id, price, volume, XOR checksum).
`timescale 1ns/1ps

module order_serializer #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] ORDER_TYPE = 8'h42
) (
    input logic               clk,
    input logic               rst_n,
    order_serializer_if.slave bus
);
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int LEVEL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W     = 136;
    localparam int FRAME_BYTES = 19;
    localparam int FRAME_W     = FRAME_BYTES * 8;

    localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(FIFO_DEPTH);
    localparam logic [4:0]         LAST_IDX   = 5'(FRAME_BYTES - 1);

    typedef enum logic [0:0] {
        IDLE,
        SEND
    } state_t;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LEVEL_W-1:0] level;
    logic [ENTRY_W-1:0] head;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               drop;

    state_t             state;
    state_t             state_next;
    logic [FRAME_W-1:0] frame;
    logic [4:0]         byte_idx;
    logic               sending;
    logic               handshake;
    logic               last_byte;

    logic               overflow_q;
    logic [15:0]        drop_cnt;

    // Checksum covers the fixed type byte plus all 17 payload bytes.
    function automatic logic [7:0] frame_checksum(input logic [ENTRY_W-1:0] e);
        logic [7:0] c;
        c = ORDER_TYPE;
        for (int i = 0; i < ENTRY_W / 8; i++) begin
            c = c ^ e[i*8 +: 8];
        end
        return c;
    endfunction

    assign full  = (level == FULL_LEVEL);
    assign empty = (level == '0);
    assign head  = mem[rd_ptr];

    // A full FIFO drops the decision even if the engine pops in the same cycle.
    assign push = bus.decision_valid && !full;
    assign drop = bus.decision_valid && full;

    assign sending   = (state == SEND);
    assign handshake = sending && bus.tx_ready;
    assign last_byte = (byte_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.decision_type, bus.d_order_id, bus.d_price, bus.d_volume};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LEVEL_W'(1);
            end else if (pop && !push) begin
                level <= level - LEVEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (bus.tx_ready && last_byte) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The frame is a shift register: the current byte always sits on top, and
    // shifting zeros in leaves tx_data at 0 once the frame has drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame    <= '0;
            byte_idx <= '0;
        end else if (pop) begin
            frame    <= {ORDER_TYPE, head, frame_checksum(head)};
            byte_idx <= '0;
        end else if (handshake) begin
            frame    <= {frame[FRAME_W-9:0], 8'h00};
            byte_idx <= byte_idx + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            overflow_q <= drop;
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    assign bus.tx_valid   = sending;
    assign bus.tx_data    = frame[FRAME_W-1 -: 8];
    assign bus.tx_last    = sending && last_byte;
    assign bus.busy       = sending;
    assign bus.fifo_level = level;
    assign bus.overflow   = overflow_q;
    assign bus.drop_count = drop_cnt;
endmodule

// File: tb/tb_order_serializer.sv
// Directed and randomized bench for order_serializer; expected frames come from
// a byte-level frame builder applied to the decisions the bench issued.
`timescale 1ns/1ps

module tb_order_serializer;
    localparam int         FIFO_DEPTH  = 4;
    localparam logic [7:0] ORDER_TYPE  = 8'h42;
    localparam int         FRAME_BYTES = 19;

    typedef struct packed {
        logic [7:0]  mtype;
        logic [63:0] id;
        logic [31:0] price;
        logic [31:0] volume;
    } dec_t;

    logic clk          = 1'b0;
    logic rst_n        = 1'b0;
    logic ready_fixed  = 1'b0;
    logic ready_random = 1'b0;
    logic ready_drv    = 1'b0;

    int cyc        = 0;
    int n_compared = 0;
    int n_mismatch = 0;
    int stall_err  = 0;
    int ovf_seen   = 0;

    logic [7:0] rx_data [$];
    logic       rx_last [$];
    int         rx_cyc  [$];
    logic [7:0] exp_q   [$];

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;

    order_serializer_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    order_serializer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ORDER_TYPE (ORDER_TYPE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign bus.tx_ready = ready_drv;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        ready_drv = ready_random ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    // Records every accepted byte and flags any change while the stream is stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.tx_valid && bus.tx_ready) begin
                rx_data.push_back(bus.tx_data);
                rx_last.push_back(bus.tx_last);
                rx_cyc.push_back(cyc);
            end
            if (prev_stall && (!bus.tx_valid || bus.tx_data !== prev_data || bus.tx_last !== prev_last)) begin
                stall_err++;
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
            prev_last  = bus.tx_last;
            if (bus.overflow) begin
                ovf_seen++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatch++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic dec_t rand_dec();
        dec_t d;
        d.mtype  = 8'($urandom);
        d.id     = {$urandom, $urandom};
        d.price  = $urandom;
        d.volume = $urandom;
        return d;
    endfunction

    task automatic drive_cycle(input logic v, input dec_t d);
        @(posedge clk);
        #1;
        bus.decision_valid = v;
        bus.decision_type  = d.mtype;
        bus.d_order_id     = d.id;
        bus.d_price        = d.price;
        bus.d_volume       = d.volume;
    endtask

    // Frame model: fields MSB-first, last byte is the XOR of the preceding 18.
    task automatic add_expected(input dec_t d);
        logic [7:0] b [$];
        logic [7:0] x;
        b.push_back(ORDER_TYPE);
        b.push_back(d.mtype);
        for (int i = 7; i >= 0; i--) b.push_back(d.id[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) b.push_back(d.price[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) b.push_back(d.volume[i*8 +: 8]);
        x = 8'h00;
        foreach (b[i]) x = x ^ b[i];
        b.push_back(x);
        foreach (b[i]) exp_q.push_back(b[i]);
    endtask

    task automatic wait_bytes(input int target, input int budget);
        int n;
        n = 0;
        while (rx_data.size() < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (rx_data.size() < target) begin
            check("byte_wait_timeout", 64'(rx_data.size()), 64'(target));
        end
    endtask

    task automatic check_stream(input string tag, input int base);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < rx_data.size()) begin
                check($sformatf("%s_data_%0d", tag, i), rx_data[base+i], exp_q[i]);
                check($sformatf("%s_last_%0d", tag, i), rx_last[base+i], (i % FRAME_BYTES) == FRAME_BYTES - 1);
            end else begin
                check($sformatf("%s_missing_%0d", tag, i), 64'(rx_data.size()), 64'(base + exp_q.size()));
                break;
            end
        end
    endtask

    task automatic set_ready(input logic rnd, input logic val);
        ready_random = rnd;
        ready_fixed  = val;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        logic [7:0] golden [FRAME_BYTES];
        dec_t d;
        dec_t da;
        int base;
        int dcyc;
        int ovf0;
        int stall0;
        int len;

        golden = '{8'h42, 8'h54, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                   8'h00, 8'h00, 8'h27, 8'h10, 8'h00, 8'h00, 8'h00, 8'h64, 8'h4D};

        bus.decision_valid = 1'b0;
        bus.decision_type  = '0;
        bus.d_order_id     = '0;
        bus.d_price        = '0;
        bus.d_volume       = '0;

        $display("[TB] reset state");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", bus.tx_valid, 1'b0);
        check("rst_tx_last", bus.tx_last, 1'b0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_overflow", bus.overflow, 1'b0);
        check("rst_fifo_level", bus.fifo_level, 0);
        check("rst_drop_count", bus.drop_count, 16'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] single frame");
        set_ready(1'b0, 1'b1);
        base = rx_data.size();
        d = '{mtype: 8'h54, id: 64'h0102030405060708, price: 32'h00002710, volume: 32'h00000064};
        drive_cycle(1'b1, d);
        dcyc = cyc;
        drive_cycle(1'b0, rand_dec());
        wait_bytes(base + FRAME_BYTES, 100);
        for (int i = 0; i < FRAME_BYTES; i++) begin
            if (base + i < rx_data.size()) begin
                check($sformatf("single_data_%0d", i), rx_data[base+i], golden[i]);
                check($sformatf("single_last_%0d", i), rx_last[base+i], i == FRAME_BYTES - 1);
            end
        end
        if (rx_cyc.size() > base) check("single_latency", 64'(rx_cyc[base] - dcyc), 64'(2));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("single_idle_valid", bus.tx_valid, 1'b0);
        check("single_idle_busy", bus.busy, 1'b0);
        check("single_idle_level", bus.fifo_level, 0);

        $display("[TB] backpressure");
        set_ready(1'b1, 1'b0);
        exp_q.delete();
        add_expected(d);
        base   = rx_data.size();
        stall0 = stall_err;
        drive_cycle(1'b1, d);
        drive_cycle(1'b0, rand_dec());
        wait_bytes(base + FRAME_BYTES, 400);
        check_stream("bp", base);
        repeat (30) @(posedge clk);
        check("bp_stall_stable", 64'(stall_err - stall0), 64'(0));
        check("bp_byte_count", 64'(rx_data.size() - base), 64'(FRAME_BYTES));

        $display("[TB] overflow");
        set_ready(1'b0, 1'b0);
        exp_q.delete();
        base = rx_data.size();
        ovf0 = ovf_seen;
        for (int k = 0; k < 6; k++) begin
            d = rand_dec();
            drive_cycle(1'b1, d);
            if (k < 5) add_expected(d);
        end
        drive_cycle(1'b0, rand_dec());
        @(negedge clk);
        check("ovf_level", bus.fifo_level, 4);
        check("ovf_drop_count", bus.drop_count, 16'd1);
        check("ovf_pulse", bus.overflow, 1'b1);
        check("ovf_busy", bus.busy, 1'b1);
        check("ovf_tx_valid", bus.tx_valid, 1'b1);
        check("ovf_tx_data", bus.tx_data, ORDER_TYPE);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ovf_pulse_count", 64'(ovf_seen - ovf0), 64'(1));
        check("ovf_pulse_ended", bus.overflow, 1'b0);
        ready_fixed = 1'b1;
        wait_bytes(base + 5 * FRAME_BYTES, 400);
        check_stream("ovf", base);
        repeat (30) @(posedge clk);
        check("ovf_byte_count", 64'(rx_data.size() - base), 64'(5 * FRAME_BYTES));

        $display("[TB] back-to-back");
        exp_q.delete();
        base = rx_data.size();
        d = rand_dec();
        add_expected(d);
        drive_cycle(1'b1, d);
        dcyc = cyc;
        d = rand_dec();
        add_expected(d);
        drive_cycle(1'b1, d);
        drive_cycle(1'b0, rand_dec());
        wait_bytes(base + 2 * FRAME_BYTES, 200);
        check_stream("b2b", base);
        if (rx_cyc.size() >= base + 2 * FRAME_BYTES) begin
            check("b2b_latency", 64'(rx_cyc[base] - dcyc), 64'(2));
            check("b2b_frame_span", 64'(rx_cyc[base+18] - rx_cyc[base]), 64'(18));
            check("b2b_gap", 64'(rx_cyc[base+19] - rx_cyc[base+18]), 64'(2));
        end

        $display("[TB] randomized bursts");
        set_ready(1'b1, 1'b0);
        stall0 = stall_err;
        for (int burst = 0; burst < 12; burst++) begin
            exp_q.delete();
            base = rx_data.size();
            len  = int'($urandom_range(1, 5));
            for (int k = 0; k < len; k++) begin
                d = rand_dec();
                add_expected(d);
                drive_cycle(1'b1, d);
                repeat ($urandom_range(0, 2)) drive_cycle(1'b0, rand_dec());
            end
            drive_cycle(1'b0, rand_dec());
            wait_bytes(base + len * FRAME_BYTES, 1500);
            check_stream($sformatf("rnd%0d", burst), base);
        end
        repeat (30) @(posedge clk);
        check("rnd_stall_stable", 64'(stall_err - stall0), 64'(0));
        check("rnd_no_drops", bus.drop_count, 16'd1);

        $display("[TB] reset mid-frame");
        set_ready(1'b0, 1'b1);
        exp_q.delete();
        base = rx_data.size();
        da = rand_dec();
        add_expected(da);
        drive_cycle(1'b1, da);
        drive_cycle(1'b1, rand_dec());
        drive_cycle(1'b0, rand_dec());
        wait_bytes(base + 7, 100);
        #2;
        check("mid_byte7", bus.tx_data, exp_q[7]);
        check("mid_level", bus.fifo_level, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_valid", bus.tx_valid, 1'b0);
        check("mid_rst_tx_last", bus.tx_last, 1'b0);
        check("mid_rst_tx_data", bus.tx_data, 8'h00);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_overflow", bus.overflow, 1'b0);
        check("mid_rst_level", bus.fifo_level, 0);
        check("mid_rst_drop_count", bus.drop_count, 16'h0000);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("mid_no_resume", 64'(rx_data.size() - base), 64'(7));
        check("mid_idle_valid", bus.tx_valid, 1'b0);

        $display("[TB] drop counter saturation");
        set_ready(1'b0, 1'b0);
        ovf0 = ovf_seen;
        for (int k = 0; k < 65545; k++) begin
            drive_cycle(1'b1, rand_dec());
        end
        drive_cycle(1'b0, rand_dec());
        @(negedge clk);
        check("sat_drop_count", bus.drop_count, 16'hFFFF);
        check("sat_level", bus.fifo_level, 4);
        check("sat_last_pulse", bus.overflow, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sat_pulse_count", 64'(ovf_seen - ovf0), 64'(65540));
        check("sat_hold", bus.drop_count, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end
endmodule
